// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of the word-addressed data memory port, with
// sub-word read-modify-write. Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses.
module load_store_unit #(
    parameter int unsigned MEM_BYTES  = 1024,
    parameter bit          BIG_ENDIAN = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_address,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    localparam logic [2:0] OP_LB  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LW  = 3'd2;
    localparam logic [2:0] OP_LBU = 3'd3;
    localparam logic [2:0] OP_LHU = 3'd4;
    localparam logic [2:0] OP_SB  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SW  = 3'd7;

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state_reg, state_next;
    logic [2:0]  op_reg;
    logic [1:0]  offset_reg;
    logic [31:0] wdata_reg;
    logic [31:0] resp_rdata_reg;
    logic        resp_error_reg;
    logic [31:0] mem_address_reg;
    logic [31:0] mem_write_data_reg;

    // Request decode, evaluated on the incoming request while idle
    logic        is_half_req, is_word_req, out_of_range, req_error;
    logic [31:0] aligned_addr;

    assign is_half_req  = (req_op == OP_LH) || (req_op == OP_LHU) || (req_op == OP_SH);
    assign is_word_req  = (req_op == OP_LW) || (req_op == OP_SW);
    assign out_of_range = (req_address >= MEM_BYTES);

`ifdef LSU_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned   = (is_half_req && req_address[0]) ||
                          (is_word_req && (req_address[1:0] != 2'b00));
    assign aligned_addr = req_address;
    assign req_error    = out_of_range || misaligned;
`else
    // Misaligned accesses silently drop the offending low address bits
    assign aligned_addr = req_address & ~(is_word_req ? 32'h3 : (is_half_req ? 32'h1 : 32'h0));
    assign req_error    = out_of_range;
`endif

    // Lane selection for the latched access
    logic        is_half_reg, is_store_reg;
    logic [4:0]  byte_shift, half_shift, lane_shift;
    logic [31:0] rd_shifted, lane_mask, merged_word, load_result;

    assign is_half_reg  = (op_reg == OP_LH) || (op_reg == OP_LHU) || (op_reg == OP_SH);
    assign is_store_reg = (op_reg == OP_SB) || (op_reg == OP_SH);
    assign byte_shift   = BIG_ENDIAN ? {~offset_reg, 3'b000} : {offset_reg, 3'b000};
    assign half_shift   = BIG_ENDIAN ? {~offset_reg[1], 4'b0000} : {offset_reg[1], 4'b0000};
    assign lane_shift   = is_half_reg ? half_shift : byte_shift;
    assign rd_shifted   = mem_read_data >> lane_shift;
    assign lane_mask    = (is_half_reg ? 32'h0000_FFFF : 32'h0000_00FF) << lane_shift;
    assign merged_word  = (mem_read_data & ~lane_mask) | ((wdata_reg << lane_shift) & lane_mask);

    always_comb begin
        load_result = mem_read_data;
        case (op_reg)
            OP_LB:   load_result = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
            OP_LH:   load_result = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
            OP_LBU:  load_result = {24'h0, rd_shifted[7:0]};
            OP_LHU:  load_result = {16'h0, rd_shifted[15:0]};
            default: load_result = mem_read_data;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_error)            state_next = RESP;
                    else if (req_op == OP_SW) state_next = WRITE;
                    else                      state_next = READ;
                end
            end
            READ: begin
                mem_read   = 1'b1;
                state_next = is_store_reg ? WRITE : RESP;
            end
            WRITE: begin
                mem_write  = 1'b1;
                state_next = RESP;
            end
            default: begin
                resp_valid = 1'b1;
                if (resp_ready) state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            op_reg             <= 3'd0;
            offset_reg         <= 2'd0;
            wdata_reg          <= 32'h0;
            resp_rdata_reg     <= 32'h0;
            resp_error_reg     <= 1'b0;
            mem_address_reg    <= 32'h0;
            mem_write_data_reg <= 32'h0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        op_reg         <= req_op;
                        offset_reg     <= aligned_addr[1:0];
                        wdata_reg      <= req_wdata;
                        resp_rdata_reg <= 32'h0;
                        resp_error_reg <= req_error;
                        if (!req_error) begin
                            mem_address_reg <= {aligned_addr[31:2], 2'b00};
                        end
                        if (req_op == OP_SW) begin
                            mem_write_data_reg <= req_wdata;
                        end
                    end
                end
                READ: begin
                    if (is_store_reg) mem_write_data_reg <= merged_word;
                    else              resp_rdata_reg     <= load_result;
                end
                default: ;
            endcase
        end
    end

    assign resp_rdata     = resp_rdata_reg;
    assign resp_error     = resp_error_reg;
    assign mem_address    = mem_address_reg;
    assign mem_write_data = mem_write_data_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed table-driven bench for load_store_unit with a behavioural word memory.
// Expectations follow LSU_MISALIGN_TRAP_EN when it is defined for the build.
module tb_load_store_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_address;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    always #5 clock = ~clock;

    load_store_unit #(.MEM_BYTES(1024), .BIG_ENDIAN(1'b1)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_address(req_address), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_error(resp_error),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    // Behavioural memory: combinational read, write on clock edge
    logic [31:0] mem [0:255];
    logic        init_mem;

    always @(posedge clock) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[4]   <= 32'h8899AABB;
            mem[8]   <= 32'h01234567;
            mem[255] <= 32'hCAFEF00D;
        end else if (mem_write) begin
            mem[mem_address[9:2]] <= mem_write_data;
        end
    end
    assign mem_read_data = mem[mem_address[9:2]];

    int          rd_total = 0, wr_total = 0, both_total = 0;
    logic [31:0] last_rd_addr = 32'h0, last_wr_addr = 32'h0, last_wr_data = 32'h0;

    always @(negedge clock) begin
        if (mem_read) begin
            rd_total++;
            last_rd_addr = mem_address;
        end
        if (mem_write) begin
            wr_total++;
            last_wr_addr = mem_address;
            last_wr_data = mem_write_data;
        end
        if (mem_read && mem_write) both_total++;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
        logic [31:0] exp_maddr;
        logic [31:0] exp_wdata;
        int          hold;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string name, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata,
                       input logic exp_err, input int exp_lat, input int exp_rd,
                       input int exp_wr, input logic [31:0] exp_maddr,
                       input logic [31:0] exp_wdata, input int hold);
        vec_t v;
        v.name = name; v.op = op; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
        v.exp_rd = exp_rd; v.exp_wr = exp_wr; v.exp_maddr = exp_maddr;
        v.exp_wdata = exp_wdata; v.hold = hold;
        vecs.push_back(v);
    endtask

    // Starts and ends just after a falling edge with the DUT idle
    task automatic run_vec(input vec_t v);
        int edges;
        int rd0, wr0;
        rd0 = rd_total;
        wr0 = wr_total;
        resp_ready  = (v.hold == 0);
        req_valid   = 1'b1;
        req_op      = v.op;
        req_address = v.addr;
        req_wdata   = v.wdata;
        check({v.name, " req_ready"}, 32'(req_ready), 32'd1);
        @(posedge clock);
        edges = 1;
        @(negedge clock);
        req_valid = 1'b0;
        while (!resp_valid && edges < 20) begin
            @(posedge clock);
            edges++;
            @(negedge clock);
        end
        $display("txn %s: op=%0d addr=%h rdata=%h err=%0b edges=%0d reads=%0d writes=%0d",
                 v.name, v.op, v.addr, resp_rdata, resp_error, edges,
                 rd_total - rd0, wr_total - wr0);
        check({v.name, " latency"}, 32'(edges), 32'(v.exp_lat));
        check({v.name, " rdata"}, resp_rdata, v.exp_rdata);
        check({v.name, " error"}, 32'(resp_error), 32'(v.exp_err));
        check({v.name, " reads"}, 32'(rd_total - rd0), 32'(v.exp_rd));
        check({v.name, " writes"}, 32'(wr_total - wr0), 32'(v.exp_wr));
        if (v.exp_rd > 0) check({v.name, " read addr"}, last_rd_addr, v.exp_maddr);
        if (v.exp_wr > 0) begin
            check({v.name, " write addr"}, last_wr_addr, v.exp_maddr);
            check({v.name, " write data"}, last_wr_data, v.exp_wdata);
        end
        for (int h = 0; h < v.hold; h++) begin
            @(posedge clock);
            @(negedge clock);
            check({v.name, " held valid"}, 32'(resp_valid), 32'd1);
            check({v.name, " held rdata"}, resp_rdata, v.exp_rdata);
            check({v.name, " held req_ready"}, 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check({v.name, " post valid"}, 32'(resp_valid), 32'd0);
        check({v.name, " post ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        int wr0;
        reset       = 1'b1;
        init_mem    = 1'b1;
        req_valid   = 1'b0;
        req_op      = 3'd0;
        req_address = 32'h0;
        req_wdata   = 32'h0;
        resp_ready  = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset    = 1'b0;
        init_mem = 1'b0;

        check("reset req_ready", 32'(req_ready), 32'd1);
        check("reset resp_valid", 32'(resp_valid), 32'd0);
        check("reset resp_error", 32'(resp_error), 32'd0);
        check("reset mem_rw", {30'h0, mem_read, mem_write}, 32'd0);
        check("reset resp_rdata", resp_rdata, 32'h0);
        check("reset mem_address", mem_address, 32'h0);
        check("reset mem_write_data", mem_write_data, 32'h0);

        //   name         op    addr          wdata         rdata         err lat rd wr maddr   wdata   hold
        add("LB 11",     3'd0, 32'h11,       32'h0,        32'hFFFFFF99, 0, 2, 1, 0, 32'h10,  32'h0, 0);
        add("LBU 11",    3'd3, 32'h11,       32'h0,        32'h00000099, 0, 2, 1, 0, 32'h10,  32'h0, 0);
        add("LW 10",     3'd2, 32'h10,       32'h0,        32'h8899AABB, 0, 2, 1, 0, 32'h10,  32'h0, 0);
        add("SB 12",     3'd5, 32'h12,       32'h0000005A, 32'h0,        0, 3, 1, 1, 32'h10,  32'h88995ABB, 0);
        add("LH 12",     3'd1, 32'h12,       32'h0,        32'h00005ABB, 0, 2, 1, 0, 32'h10,  32'h0, 0);
        add("SH 10",     3'd6, 32'h10,       32'hFFFF8001, 32'h0,        0, 3, 1, 1, 32'h10,  32'h80015ABB, 0);
        add("LH 10",     3'd1, 32'h10,       32'h0,        32'hFFFF8001, 0, 2, 1, 0, 32'h10,  32'h0, 0);
        add("LHU 10",    3'd4, 32'h10,       32'h0,        32'h00008001, 0, 2, 1, 0, 32'h10,  32'h0, 0);
        add("LW hold",   3'd2, 32'h10,       32'h0,        32'h80015ABB, 0, 2, 1, 0, 32'h10,  32'h0, 5);
        add("LW 400",    3'd2, 32'h400,      32'h0,        32'h0,        1, 1, 0, 0, 32'h0,   32'h0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        add("LH 13",     3'd1, 32'h13,       32'h0,        32'h0,        1, 1, 0, 0, 32'h0,   32'h0, 0);
`else
        add("LH 13",     3'd1, 32'h13,       32'h0,        32'h00005ABB, 0, 2, 1, 0, 32'h10,  32'h0, 0);
`endif
        add("SW 20",     3'd7, 32'h20,       32'h11223344, 32'h0,        0, 2, 0, 1, 32'h20,  32'h11223344, 0);
        add("LB 20",     3'd0, 32'h20,       32'h0,        32'h00000011, 0, 2, 1, 0, 32'h20,  32'h0, 0);
        add("LB 23",     3'd0, 32'h23,       32'h0,        32'h00000044, 0, 2, 1, 0, 32'h20,  32'h0, 0);
        add("LB 3FF",    3'd0, 32'h3FF,      32'h0,        32'h0000000D, 0, 2, 1, 0, 32'h3FC, 32'h0, 0);
        add("LB 3FC",    3'd0, 32'h3FC,      32'h0,        32'hFFFFFFCA, 0, 2, 1, 0, 32'h3FC, 32'h0, 0);
        add("LBU 3FC",   3'd3, 32'h3FC,      32'h0,        32'h000000CA, 0, 2, 1, 0, 32'h3FC, 32'h0, 0);
        add("SB 3FF",    3'd5, 32'h3FF,      32'hFFFFFF80, 32'h0,        0, 3, 1, 1, 32'h3FC, 32'hCAFEF080, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        add("SW 3FE",    3'd7, 32'h3FE,      32'hDEADBEEF, 32'h0,        1, 1, 0, 0, 32'h0,   32'h0, 0);
        add("LW 3FC",    3'd2, 32'h3FC,      32'h0,        32'hCAFEF080, 0, 2, 1, 0, 32'h3FC, 32'h0, 0);
`else
        add("SW 3FE",    3'd7, 32'h3FE,      32'hDEADBEEF, 32'h0,        0, 2, 0, 1, 32'h3FC, 32'hDEADBEEF, 0);
        add("LW 3FC",    3'd2, 32'h3FC,      32'h0,        32'hDEADBEEF, 0, 2, 1, 0, 32'h3FC, 32'h0, 0);
`endif
        add("SB far",    3'd5, 32'h7FFFFFFF, 32'h12,       32'h0,        1, 1, 0, 0, 32'h0,   32'h0, 0);
        add("LW top",    3'd2, 32'hFFFFFFFC, 32'h0,        32'h0,        1, 1, 0, 0, 32'h0,   32'h0, 0);

        foreach (vecs[i]) run_vec(vecs[i]);

        check("mem word 10", mem[4], 32'h80015ABB);
        check("mem word 20", mem[8], 32'h11223344);

        // Reset during the READ cycle of a byte store aborts it without a write
        wr0         = wr_total;
        req_valid   = 1'b1;
        req_op      = 3'd5;
        req_address = 32'h12;
        req_wdata   = 32'h000000A5;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        check("abort in READ", 32'(mem_read), 32'd1);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("abort req_ready", 32'(req_ready), 32'd1);
        check("abort resp_valid", 32'(resp_valid), 32'd0);
        repeat (4) begin
            @(posedge clock);
            @(negedge clock);
        end
        $display("txn abort SB: writes=%0d mem=%h", wr_total - wr0, mem[4]);
        check("abort writes", 32'(wr_total - wr0), 32'd0);
        check("abort mem word", mem[4], 32'h80015ABB);
        check("abort resp_valid late", 32'(resp_valid), 32'd0);
        check("read/write overlap", 32'(both_total), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
